bp_lce_req_burst: RTL and testbench

- Parametrised LCE request handler. Accepts cache misses and uncached accesses from the cache engine and issues BedRock LCE request messages to the CCE.
- Generalises the single-dword request path in three ways:
  - configurable data channel width (data_width_p);
  - multi-beat uncached stores up to a full block;
  - dual-source credit return, with up to 2 credits returned per cycle.
- Sits between the cache (I$/D$ engine interface) and the LCE request network, beside the LCE command handler.

---
 rtl/bp_lce_req_burst.sv | 257 +++++++++++++++++++++++++
 tb/tb_bp_lce_req_burst.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_lce_req_burst.sv
// LCE request handler: turns cache misses and uncached accesses into BedRock LCE
// request messages, with multi-beat uncached stores and dual-source credit return.
module bp_lce_req_burst #(
  parameter int paddr_width_p      = 40,
  parameter int lce_id_width_p     = 4,
  parameter int cce_id_width_p     = 4,
  parameter int assoc_p            = 8,
  parameter int sets_p             = 64,
  parameter int block_width_p      = 512,
  parameter int fill_width_p       = block_width_p,
  parameter int req_width_p        = block_width_p,
  parameter int data_width_p       = 64,
  parameter int credits_p          = 8,
  parameter bit non_excl_reads_p   = 1'b0,
  parameter int metadata_latency_p = 0,
  localparam int way_id_width_lp             = (assoc_p > 1) ? $clog2(assoc_p) : 1,
  localparam int cache_req_width_lp          = 4 + paddr_width_p + 3 + req_width_p,
  localparam int cache_req_metadata_width_lp = way_id_width_lp + 1,
  localparam int lce_req_msg_header_width_lp =
    way_id_width_lp + 1 + lce_id_width_p + cce_id_width_p + 3 + paddr_width_p + 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [lce_id_width_p-1:0]              lce_id_i,
  input  logic [1:0]                             lce_mode_i,
  input  logic                                   sync_done_i,
  output logic                                   ready_o,
  input  logic [cache_req_width_lp-1:0]          cache_req_i,
  input  logic                                   cache_req_v_i,
  output logic                                   cache_req_yumi_o,
  input  logic [cache_req_metadata_width_lp-1:0] cache_req_metadata_i,
  input  logic                                   cache_req_metadata_v_i,
  input  logic                                   cache_req_complete_i,
  input  logic                                   uc_store_req_complete_i,
  output logic                                   credits_full_o,
  output logic                                   credits_empty_o,
  output logic [lce_req_msg_header_width_lp-1:0] lce_req_header_o,
  output logic                                   lce_req_header_v_o,
  input  logic                                   lce_req_header_ready_and_i,
  output logic [data_width_p-1:0]                lce_req_data_o,
  output logic                                   lce_req_data_v_o,
  input  logic                                   lce_req_data_ready_and_i,
  output logic                                   lce_req_last_o
);

  if (metadata_latency_p != 0 && metadata_latency_p != 1) begin : g_bad_md_latency
    $error("metadata_latency_p must be 0 or 1");
  end
  if (data_width_p < 64 || (req_width_p % data_width_p) != 0 || fill_width_p < data_width_p
      || sets_p < 1 || credits_p < 1) begin : g_bad_geometry
    $error("inconsistent bp_lce_req_burst geometry");
  end

  localparam int max_beats_lp       = req_width_p / data_width_p;
  localparam int beat_width_lp      = (max_beats_lp > 1) ? $clog2(max_beats_lp) : 1;
  localparam int data_bytes_lp      = data_width_p / 8;
  localparam int lg_data_bytes_lp   = $clog2(data_bytes_lp);
  localparam int lg_block_bytes_lp  = $clog2(block_width_p / 8);
  localparam int cnt_width_lp       = $clog2(credits_p + 1);
  localparam logic [2:0] block_size_lp = 3'(lg_block_bytes_lp);

  typedef enum logic [1:0] {e_reset, e_ready, e_send_data, e_send_cached} state_e;
  typedef enum logic [1:0] {
    e_lce_mode_uncached = 2'd0, e_lce_mode_normal = 2'd1, e_lce_mode_nonspec = 2'd2
  } lce_mode_e;
  typedef enum logic [3:0] {
    e_miss_load = 4'd0, e_miss_store = 4'd1, e_uc_load = 4'd2, e_uc_store = 4'd3
  } cache_req_msg_e;
  typedef enum logic [3:0] {
    e_bedrock_req_rd_miss = 4'd0, e_bedrock_req_wr_miss = 4'd1,
    e_bedrock_req_uc_rd   = 4'd2, e_bedrock_req_uc_wr   = 4'd3
  } bedrock_req_e;

  typedef struct packed {
    logic [req_width_p-1:0]   data;
    logic [2:0]               size;
    logic [paddr_width_p-1:0] addr;
    logic [3:0]               msg_type;
  } cache_req_s;

  typedef struct packed {
    logic [way_id_width_lp-1:0] way;
    logic                       dirty;
  } metadata_s;

  typedef struct packed {
    logic [way_id_width_lp-1:0] lru_way_id;
    logic                       non_exclusive;
    logic [lce_id_width_p-1:0]  src_id;
    logic [cce_id_width_p-1:0]  dst_id;
    logic [2:0]                 size;
    logic [paddr_width_p-1:0]   addr;
    logic [3:0]                 msg_type;
  } req_header_s;

  state_e                   state_q, state_d;
  logic [beat_width_lp-1:0] beat_q, beat_d, last_beat_q, last_beat_d;
  logic [cnt_width_lp-1:0]  cnt_q, cnt_d;
  logic [cnt_width_lp:0]    cnt_inc, cnt_dec;
  logic                     md_v_q, md_v_d, md_valid;
  cache_req_s               req_li, req_q;
  metadata_s                md_li, md_q, md_eff;
  req_header_s              hdr;
  logic                     ready, yumi, hdr_v, data_v, last, hdr_hs, credits_full;
  logic                     coherent_mode, is_load_miss;
  logic [cce_id_width_p-1:0] uc_dst_id, cached_dst_id;

  logic [max_beats_lp-1:0][data_width_p-1:0] req_beats;
  logic [data_bytes_lp-1:0][7:0]             beat_bytes;
  logic [lg_data_bytes_lp-1:0]               byte_mask;
  logic                                      unused_dirty;

  assign req_li        = cache_req_i;
  assign md_li         = cache_req_metadata_i;
  assign unused_dirty  = md_q.dirty;
  assign coherent_mode = (lce_mode_i == e_lce_mode_normal) | (lce_mode_i == e_lce_mode_nonspec);
  assign is_load_miss  = (req_q.msg_type == e_miss_load);
  // CCEs are interleaved on block address bits just above the block offset.
  assign uc_dst_id     = req_li.addr[lg_block_bytes_lp +: cce_id_width_p];
  assign cached_dst_id = req_q.addr[lg_block_bytes_lp +: cce_id_width_p];
  assign md_valid      = md_v_q | ((metadata_latency_p == 0) & cache_req_metadata_v_i);
  assign md_eff        = (metadata_latency_p == 0 && cache_req_metadata_v_i) ? md_li : md_q;
  assign credits_full  = (cnt_q == cnt_width_lp'(credits_p));

  function automatic logic [beat_width_lp-1:0] last_beat_of(input logic [2:0] size);
    int n;
    if (int'(size) <= lg_data_bytes_lp) n = 0;
    else n = (1 << (int'(size) - lg_data_bytes_lp)) - 1;
    if (n > max_beats_lp - 1) n = max_beats_lp - 1;
    return beat_width_lp'(n);
  endfunction

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
    state_d     = state_q;
    beat_d      = beat_q;
    last_beat_d = last_beat_q;
    ready       = 1'b0;
    yumi        = 1'b0;
    hdr_v       = 1'b0;
    data_v      = 1'b0;
    last        = 1'b0;
    hdr         = '0;
    hdr.src_id  = lce_id_i;
    case (state_q)
      e_reset: state_d = e_ready;
      e_ready: begin
        ready      = ~credits_full & ((lce_mode_i == e_lce_mode_uncached) | sync_done_i);
        hdr.addr   = req_li.addr;
        hdr.size   = req_li.size;
        hdr.dst_id = uc_dst_id;
        if (ready & cache_req_v_i) begin
          case (req_li.msg_type)
            e_miss_load, e_miss_store: begin
              yumi = coherent_mode & sync_done_i;
              if (yumi) state_d = e_send_cached;
            end
            e_uc_store: begin
              hdr_v        = 1'b1;
              hdr.msg_type = e_bedrock_req_uc_wr;
              yumi         = lce_req_header_ready_and_i;
              if (yumi) begin
                beat_d      = '0;
                last_beat_d = last_beat_of(req_li.size);
                state_d     = e_send_data;
              end
            end
            e_uc_load: begin
              hdr_v        = 1'b1;
              last         = 1'b1;
              hdr.msg_type = e_bedrock_req_uc_rd;
              yumi         = lce_req_header_ready_and_i;
            end
            default: ;
          endcase
        end
      end
      e_send_data: begin
        data_v = 1'b1;
        last   = (beat_q == last_beat_q);
        if (lce_req_data_ready_and_i) begin
          if (last) state_d = e_ready;
          else      beat_d  = beat_q + 1'b1;
        end
      end
      e_send_cached: begin
        hdr_v             = md_valid;
        last              = md_valid;
        hdr.addr          = req_q.addr;
        hdr.size          = block_size_lp;
        hdr.dst_id        = cached_dst_id;
        hdr.lru_way_id    = md_eff.way;
        hdr.msg_type      = is_load_miss ? e_bedrock_req_rd_miss : e_bedrock_req_wr_miss;
        hdr.non_exclusive = non_excl_reads_p & is_load_miss;
        if (hdr_v & lce_req_header_ready_and_i) state_d = e_ready;
      end
      default: state_d = e_reset;
    endcase
  end

  // Sub-channel stores replicate their low 2^size bytes across the whole beat.
  assign req_beats  = req_q.data;
  assign beat_bytes = req_beats[beat_q];
  assign byte_mask  = (req_q.size < 3'(lg_data_bytes_lp))
                      ? lg_data_bytes_lp'((1 << req_q.size) - 1) : '1;

  always_comb begin
    lce_req_data_o = '0;
    for (int i = 0; i < data_bytes_lp; i++)
      lce_req_data_o[8*i +: 8] = beat_bytes[lg_data_bytes_lp'(i) & byte_mask];
  end

  always_comb begin
    if (metadata_latency_p == 1)
      md_v_d = yumi ? 1'b0 : (cache_req_metadata_v_i | md_v_q);
    else
      md_v_d = cache_req_metadata_v_i ? 1'b1 : (~yumi & md_v_q);
  end

  assign hdr_hs  = hdr_v & lce_req_header_ready_and_i;
  assign cnt_inc = {1'b0, cnt_q} + (cnt_width_lp+1)'(hdr_hs);
  assign cnt_dec = (cnt_width_lp+1)'(cache_req_complete_i) + (cnt_width_lp+1)'(uc_store_req_complete_i);
  assign cnt_d   = (cnt_inc < cnt_dec) ? '0 : cnt_width_lp'(cnt_inc - cnt_dec);

  credit_underflow_a: assert property (@(posedge clk_i) disable iff (reset_i) cnt_inc >= cnt_dec);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_reset;
      cnt_q   <= '0;
      beat_q  <= '0;
      md_v_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      md_v_q  <= md_v_d;
    end
  end

  // NOTE: payload registers carry no reset; they are only read while state/valid qualifies them.
  always_ff @(posedge clk_i) begin
    last_beat_q <= last_beat_d;
    if (yumi) req_q <= req_li;
    if (cache_req_metadata_v_i) md_q <= md_li;
  end

  assign ready_o            = ready;
  assign cache_req_yumi_o   = yumi;
  assign lce_req_header_o   = hdr;
  assign lce_req_header_v_o = hdr_v;
  assign lce_req_data_v_o   = data_v;
  assign lce_req_last_o     = last;
  assign credits_full_o     = credits_full;
  assign credits_empty_o    = (cnt_q == '0);

endmodule

// File: tb/tb_bp_lce_req_burst.sv
// Directed bench for bp_lce_req_burst: UC store bursts, cached misses, credits,
// backpressure, mode gating and mid-burst reset.
module tb_bp_lce_req_burst;

  localparam int PADDR = 40, LCE = 4, CCE = 4, WAY = 3, BLK = 512, REQ = 512, DW = 64, CRED = 2;
  localparam int HDRW = WAY + 1 + LCE + CCE + 3 + PADDR + 4;
  localparam logic [LCE-1:0] LCE_ID = 4'h5;

  typedef struct packed {
    logic [REQ-1:0]   data;
    logic [2:0]       size;
    logic [PADDR-1:0] addr;
    logic [3:0]       msg_type;
  } req_s;
  typedef struct packed {
    logic [WAY-1:0] way;
    logic           dirty;
  } md_s;
  typedef struct packed {
    logic [WAY-1:0]   lru_way_id;
    logic             non_exclusive;
    logic [LCE-1:0]   src_id;
    logic [CCE-1:0]   dst_id;
    logic [2:0]       size;
    logic [PADDR-1:0] addr;
    logic [3:0]       msg_type;
  } hdr_s;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_i, sync_done_i, ready_o, cache_req_v_i, yumi, md_v;
  logic [1:0]      lce_mode_i;
  req_s            req;
  md_s             md;
  logic            cache_complete, uc_complete, full, empty;
  logic [HDRW-1:0] hdr_raw;
  hdr_s            hdr;
  logic            hdr_v, hdr_ready, data_v, data_ready, last;
  logic [DW-1:0]   data;

  assign hdr = hdr_raw;

  int errors = 0;
  int checks = 0;

  bp_lce_req_burst #(
    .paddr_width_p(PADDR), .lce_id_width_p(LCE), .cce_id_width_p(CCE), .assoc_p(8), .sets_p(64),
    .block_width_p(BLK), .fill_width_p(BLK), .req_width_p(REQ), .data_width_p(DW),
    .credits_p(CRED), .non_excl_reads_p(1'b1), .metadata_latency_p(1)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .lce_id_i(LCE_ID), .lce_mode_i(lce_mode_i),
    .sync_done_i(sync_done_i), .ready_o(ready_o), .cache_req_i(req), .cache_req_v_i(cache_req_v_i),
    .cache_req_yumi_o(yumi), .cache_req_metadata_i(md), .cache_req_metadata_v_i(md_v),
    .cache_req_complete_i(cache_complete), .uc_store_req_complete_i(uc_complete),
    .credits_full_o(full), .credits_empty_o(empty),
    .lce_req_header_o(hdr_raw), .lce_req_header_v_o(hdr_v), .lce_req_header_ready_and_i(hdr_ready),
    .lce_req_data_o(data), .lce_req_data_v_o(data_v), .lce_req_data_ready_and_i(data_ready),
    .lce_req_last_o(last)
  );

  function automatic hdr_s mk_hdr(input logic [3:0] t, input logic [PADDR-1:0] a,
                                  input logic [2:0] sz, input logic [WAY-1:0] way, input logic ne);
    hdr_s h;
    h.lru_way_id = way;  h.non_exclusive = ne;  h.src_id = LCE_ID;
    h.dst_id = a[9:6];   h.size = sz;           h.addr = a;  h.msg_type = t;
    return h;
  endfunction

  function automatic logic [REQ-1:0] block_data(input logic [7:0] base);
    logic [REQ-1:0] d;
    for (int i = 0; i < REQ/8; i++) d[8*i +: 8] = base + 8'(i);
    return d;
  endfunction

  function automatic logic [DW-1:0] exp_beat(input logic [7:0] base, input int k);
    logic [DW-1:0] e;
    for (int b = 0; b < DW/8; b++) e[8*b +: 8] = base + 8'(8*k + b);
    return e;
  endfunction

  task automatic send_uc_store_hdr(input logic [PADDR-1:0] a, input logic [2:0] sz,
                                   input logic [REQ-1:0] d, input string tag);
    @(negedge clk);
    req.msg_type = 4'd3; req.addr = a; req.size = sz; req.data = d; cache_req_v_i = 1'b1;
    #1;
    checks++;
    if ({hdr_v, last, yumi} !== 3'b101) begin
      errors++; $display("FAIL %s_hdr_ctl: v/last/yumi=%b%b%b want 101", tag, hdr_v, last, yumi);
    end
    checks++;
    if (hdr !== mk_hdr(4'd3, a, sz, '0, 1'b0)) begin
      errors++; $display("FAIL %s_hdr: got %h want %h", tag, hdr, mk_hdr(4'd3, a, sz, '0, 1'b0));
    end
    @(posedge clk); #1;
    cache_req_v_i = 1'b0;
  endtask

  task automatic return_credit(input bit uc, input string tag);
    @(negedge clk);
    if (uc) uc_complete = 1'b1; else cache_complete = 1'b1;
    @(negedge clk);
    uc_complete = 1'b0; cache_complete = 1'b0;
    #1;
    checks++;
    if ({empty, full} !== 2'b10) begin
      errors++; $display("FAIL %s_credit_return: empty/full=%b%b want 10", tag, empty, full);
    end
  endtask

  task automatic do_miss(input logic [3:0] t, input logic [PADDR-1:0] a,
                         input logic [WAY-1:0] way, input logic ne, input string tag);
    @(negedge clk);
    req.msg_type = t; req.addr = a; req.size = 3'd3; req.data = '0; cache_req_v_i = 1'b1;
    #1;
    checks++;
    if ({yumi, hdr_v} !== 2'b10) begin
      errors++; $display("FAIL %s_accept: yumi/hdr_v=%b%b want 10", tag, yumi, hdr_v);
    end
    @(posedge clk); #1;
    cache_req_v_i = 1'b0;
    @(negedge clk);
    md.way = way; md.dirty = 1'b0; md_v = 1'b1;
    #1;
    checks++;
    if (hdr_v !== 1'b0) begin
      errors++; $display("FAIL %s_early_hdr: hdr_v=%b want 0", tag, hdr_v);
    end
    @(posedge clk); #1;
    md_v = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({hdr_v, last} !== 2'b11) begin
      errors++; $display("FAIL %s_hdr_ctl: hdr_v/last=%b%b want 11", tag, hdr_v, last);
    end
    checks++;
    if (hdr !== mk_hdr((t == 4'd0) ? 4'd0 : 4'd1, a, 3'd6, way, ne)) begin
      errors++; $display("FAIL %s_hdr: got %h want %h", tag, hdr, mk_hdr((t == 4'd0) ? 4'd0 : 4'd1, a, 3'd6, way, ne));
    end
    @(negedge clk); #1;
    checks++;
    if (hdr_v !== 1'b0) begin
      errors++; $display("FAIL %s_hdr_drop: hdr_v=%b want 0", tag, hdr_v);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({ready_o, yumi, hdr_v, data_v, last} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: rdy/yumi/hv/dv/last=%b%b%b%b%b want 00000", ready_o, yumi, hdr_v, data_v, last);
    end
    checks++;
    if ({empty, full} !== 2'b10) begin
      errors++; $display("FAIL reset_credits: empty/full=%b%b want 10", empty, full);
    end
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_to_ready: ready_o=%b want 1", ready_o);
    end
  endtask

  task automatic test_uc_store_block();
    send_uc_store_hdr(40'h00_8000_1040, 3'd6, block_data(8'h00), "st64");
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      checks++;
      if ({data_v, hdr_v, last} !== {2'b10, (k == 7)} || data !== exp_beat(8'h00, k)) begin
        errors++; $display("FAIL st64_beat%0d: dv/hv/last=%b%b%b data=%h want %b%b%b %h", k, data_v, hdr_v, last, data, 1'b1, 1'b0, (k == 7), exp_beat(8'h00, k));
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({data_v, ready_o, empty} !== 3'b010) begin
      errors++; $display("FAIL st64_done: dv/rdy/empty=%b%b%b want 010", data_v, ready_o, empty);
    end
    return_credit(1'b1, "st64");
  endtask

  task automatic test_uc_store_word();
    logic [REQ-1:0] d;
    d = '0;
    d[63:0] = 64'h12345678_DEADBEEF;
    send_uc_store_hdr(40'h00_0000_0204, 3'd2, d, "st4");
    @(negedge clk); #1;
    checks++;
    if ({data_v, last} !== 2'b11 || data !== 64'hDEADBEEF_DEADBEEF) begin
      errors++; $display("FAIL st4_beat: dv/last=%b%b data=%h want 11 deadbeefdeadbeef", data_v, last, data);
    end
    @(negedge clk); #1;
    checks++;
    if ({data_v, ready_o} !== 2'b01) begin
      errors++; $display("FAIL st4_done: dv/rdy=%b%b want 01", data_v, ready_o);
    end
    return_credit(1'b1, "st4");
  endtask

  task automatic test_load_miss();
    do_miss(4'd0, 40'h12_3456_7880, 3'd3, 1'b1, "ldmiss");
    checks++;
    if ({ready_o, empty} !== 2'b10) begin
      errors++; $display("FAIL ldmiss_after: rdy/empty=%b%b want 10", ready_o, empty);
    end
    return_credit(1'b0, "ldmiss");
  endtask

  task automatic test_credits();
    do_miss(4'd1, 40'h00_0000_1100, 3'd5, 1'b0, "stmiss");
    do_miss(4'd0, 40'h00_0000_2340, 3'd1, 1'b1, "ldmiss2");
    checks++;
    if ({full, ready_o, empty} !== 3'b100) begin
      errors++; $display("FAIL cred_full: full/rdy/empty=%b%b%b want 100", full, ready_o, empty);
    end
    @(negedge clk);
    req.msg_type = 4'd2; req.addr = 40'h00_0000_0400; req.size = 3'd3; cache_req_v_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({yumi, hdr_v} !== 2'b00) begin
        errors++; $display("FAIL cred_block%0d: yumi/hdr_v=%b%b want 00", c, yumi, hdr_v);
      end
      @(negedge clk);
    end
    cache_req_v_i = 1'b0; cache_complete = 1'b1; uc_complete = 1'b1;
    @(negedge clk);
    cache_complete = 1'b0; uc_complete = 1'b0;
    #1;
    checks++;
    if ({empty, full, ready_o} !== 3'b101) begin
      errors++; $display("FAIL cred_dual_return: empty/full/rdy=%b%b%b want 101", empty, full, ready_o);
    end
  endtask

  task automatic test_backpressure();
    int k, stalls, cycles;
    logic [7:0] base;
    base = 8'h80;
    send_uc_store_hdr(40'h00_0000_3000, 3'd6, block_data(base), "bp");
    k = 0; stalls = 0; cycles = 0;
    while (k < 8 && cycles < 20) begin
      @(negedge clk);
      data_ready = !(k == 2 && stalls < 3);
      #1;
      checks++;
      if ({data_v, last} !== {1'b1, (k == 7)} || data !== exp_beat(base, k)) begin
        errors++; $display("FAIL bp_beat%0d_cyc%0d: dv/last=%b%b data=%h want %b%b %h", k, cycles, data_v, last, data, 1'b1, (k == 7), exp_beat(base, k));
      end
      if (data_ready) k++; else stalls++;
      cycles++;
    end
    data_ready = 1'b1;
    checks++;
    if (k != 8) begin
      errors++; $display("FAIL bp_timeout: beats=%0d want 8", k);
    end
    @(negedge clk); #1;
    checks++;
    if (data_v !== 1'b0) begin
      errors++; $display("FAIL bp_extra_beat: dv=%b want 0", data_v);
    end
    return_credit(1'b1, "bp");
  endtask

  task automatic test_mode();
    @(negedge clk);
    lce_mode_i = 2'd0; sync_done_i = 1'b0;
    req.msg_type = 4'd0; req.addr = 40'h00_0000_5000; req.size = 3'd3; cache_req_v_i = 1'b1;
    #1;
    checks++;
    if ({ready_o, yumi, hdr_v} !== 3'b100) begin
      errors++; $display("FAIL mode_uc_miss: rdy/yumi/hv=%b%b%b want 100", ready_o, yumi, hdr_v);
    end
    @(negedge clk);
    lce_mode_i = 2'd1;
    #1;
    checks++;
    if ({ready_o, yumi} !== 2'b00) begin
      errors++; $display("FAIL mode_nosync: rdy/yumi=%b%b want 00", ready_o, yumi);
    end
    @(negedge clk);
    cache_req_v_i = 1'b0; sync_done_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL mode_restore: rdy=%b want 1", ready_o);
    end
  endtask

  task automatic test_reset_mid_burst();
    send_uc_store_hdr(40'h00_0000_6000, 3'd6, block_data(8'h40), "rst");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      checks++;
      if (data_v !== 1'b1 || data !== exp_beat(8'h40, k)) begin
        errors++; $display("FAIL rst_beat%0d: dv=%b data=%h want 1 %h", k, data_v, data, exp_beat(8'h40, k));
      end
    end
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    checks++;
    if ({hdr_v, data_v, last, ready_o, empty} !== 5'b00001) begin
      errors++; $display("FAIL rst_abandon: hv/dv/last/rdy/empty=%b%b%b%b%b want 00001", hdr_v, data_v, last, ready_o, empty);
    end
    @(negedge clk);
    req.msg_type = 4'd2; req.addr = 40'h00_0000_2208; req.size = 3'd3; cache_req_v_i = 1'b1;
    #1;
    checks++;
    if ({hdr_v, last, yumi} !== 3'b111 || hdr !== mk_hdr(4'd2, 40'h00_0000_2208, 3'd3, '0, 1'b0)) begin
      errors++; $display("FAIL rst_uc_load: hv/last/yumi=%b%b%b hdr=%h want 111 %h", hdr_v, last, yumi, hdr, mk_hdr(4'd2, 40'h00_0000_2208, 3'd3, '0, 1'b0));
    end
    @(posedge clk); #1;
    cache_req_v_i = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({hdr_v, data_v, empty} !== 3'b000) begin
      errors++; $display("FAIL rst_uc_load_after: hv/dv/empty=%b%b%b want 000", hdr_v, data_v, empty);
    end
    return_credit(1'b0, "rst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; lce_mode_i = 2'd1; sync_done_i = 1'b1; req = '0; cache_req_v_i = 1'b0;
    md = '0; md_v = 1'b0; cache_complete = 1'b0; uc_complete = 1'b0;
    hdr_ready = 1'b1; data_ready = 1'b1;
    test_reset();
    test_uc_store_block();
    test_uc_store_word();
    test_load_miss();
    test_credits();
    test_backpressure();
    test_mode();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
